// File: rtl/sdram_wb_arbiter.sv
// Two-master Wishbone B4 round-robin arbiter in front of the SDRAM controller slave port.
// Optional slave-stall timeout with abort is enabled by defining SDRAM_WB_ARB_TIMEOUT_EN.
module sdram_wb_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int SW      = 4,
   parameter int TIMEOUT = 256
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_n,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_dat_i,
   input  logic [SW-1:0] m0_sel_i,
   input  logic [2:0]    m0_cti_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_dat_i,
   input  logic [SW-1:0] m1_sel_i,
   input  logic [2:0]    m1_cti_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [AW-1:0] s_addr_o,
   output logic [DW-1:0] s_dat_o,
   output logic [SW-1:0] s_sel_o,
   output logic [2:0]    s_cti_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   output logic [1:0]    gnt_o
);

`ifdef SDRAM_WB_ARB_TIMEOUT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2, ABORT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
`endif

   if (TIMEOUT < 2) begin : g_timeout_range
      $error("sdram_wb_arbiter: TIMEOUT must be >= 2");
   end

   state_t state_q, state_d;
   logic   last_gnt_q, last_gnt_d;
   logic   tmo_hit;

   // last1 = 1 means m1 owned most recently, so m0 wins a tie
   function automatic state_t arbitrate(input logic req0, input logic req1, input logic last1);
      if (req0 && req1) return last1 ? OWN0 : OWN1;
      if (req0)         return OWN0;
      if (req1)         return OWN1;
      return IDLE;
   endfunction

`ifdef SDRAM_WB_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          abt_own_q, abt_own_d;
   logic          own_stall;

   always_comb begin
      own_stall = 1'b0;
      if (state_q == OWN0) own_stall = m0_stb_i && !s_ack_i;
      if (state_q == OWN1) own_stall = m1_stb_i && !s_ack_i;
   end

   assign tmo_hit = own_stall && (tmo_cnt_q == TW'(TIMEOUT - 1));

   always_comb begin
      tmo_cnt_d = '0;
      if (own_stall && (state_d == state_q)) tmo_cnt_d = tmo_cnt_q + TW'(1);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         tmo_cnt_q <= '0;
         abt_own_q <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         abt_own_q <= abt_own_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
      abt_own_d  = abt_own_q;
`endif
      case (state_q)
         IDLE: state_d = arbitrate(m0_cyc_i, m1_cyc_i, last_gnt_q);
         OWN0: begin
            if (!m0_cyc_i) state_d = arbitrate(1'b0, m1_cyc_i, last_gnt_q);
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d   = ABORT;
               abt_own_d = 1'b0;
            end
`endif
         end
         OWN1: begin
            if (!m1_cyc_i) state_d = arbitrate(m0_cyc_i, 1'b0, last_gnt_q);
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
            else if (tmo_hit) begin
               state_d   = ABORT;
               abt_own_d = 1'b1;
            end
`endif
         end
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
         ABORT: begin
            if (abt_own_q && !m1_cyc_i)       state_d = arbitrate(m0_cyc_i, 1'b0, last_gnt_q);
            else if (!abt_own_q && !m0_cyc_i) state_d = arbitrate(1'b0, m1_cyc_i, last_gnt_q);
         end
`endif
         default: state_d = IDLE;
      endcase
      if (state_d == OWN0) last_gnt_d = 1'b0;
      if (state_d == OWN1) last_gnt_d = 1'b1;
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // Outputs are gated by reset so a reset cycle never forwards an ack
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_cti_o  = '0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      gnt_o    = 2'b00;
      if (wb_rst_n) begin
         case (state_q)
            OWN0: begin
               s_cyc_o  = m0_cyc_i;
               s_stb_o  = m0_stb_i;
               s_we_o   = m0_we_i;
               s_addr_o = m0_addr_i;
               s_dat_o  = m0_dat_i;
               s_sel_o  = m0_sel_i;
               s_cti_o  = m0_cti_i;
               m0_ack_o = s_ack_i;
               m0_dat_o = s_dat_i;
               m0_err_o = tmo_hit;
               gnt_o    = 2'b01;
            end
            OWN1: begin
               s_cyc_o  = m1_cyc_i;
               s_stb_o  = m1_stb_i;
               s_we_o   = m1_we_i;
               s_addr_o = m1_addr_i;
               s_dat_o  = m1_dat_i;
               s_sel_o  = m1_sel_i;
               s_cti_o  = m1_cti_i;
               m1_ack_o = s_ack_i;
               m1_dat_o = s_dat_i;
               m1_err_o = tmo_hit;
               gnt_o    = 2'b10;
            end
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
            ABORT: gnt_o = abt_own_q ? 2'b10 : 2'b01;
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed and randomized checks of sdram_wb_arbiter against a tenure-level ownership model.
module tb_sdram_wb_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_n;
   logic [1:0]    mcyc, mstb, mwe;
   logic [AW-1:0] maddr [2];
   logic [DW-1:0] mdat  [2];
   logic [SW-1:0] msel  [2];
   logic [2:0]    mcti  [2];
   logic [DW-1:0] dat_o [2];
   logic [1:0]    ack_o, err_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0] s_addr_o;
   logic [DW-1:0] s_dat_o;
   logic [SW-1:0] s_sel_o;
   logic [2:0]    s_cti_o;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i;
   logic [1:0]    gnt_o;

   int ntests = 0;
   int nfail  = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   sdram_wb_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT(8)) dut (
      .wb_clk_i (wb_clk_i),  .wb_rst_n (wb_rst_n),
      .m0_cyc_i (mcyc[0]),   .m0_stb_i (mstb[0]),   .m0_we_i (mwe[0]),
      .m0_addr_i(maddr[0]),  .m0_dat_i (mdat[0]),   .m0_sel_i(msel[0]),
      .m0_cti_i (mcti[0]),   .m0_dat_o (dat_o[0]),  .m0_ack_o(ack_o[0]),
      .m0_err_o (err_o[0]),
      .m1_cyc_i (mcyc[1]),   .m1_stb_i (mstb[1]),   .m1_we_i (mwe[1]),
      .m1_addr_i(maddr[1]),  .m1_dat_i (mdat[1]),   .m1_sel_i(msel[1]),
      .m1_cti_i (mcti[1]),   .m1_dat_o (dat_o[1]),  .m1_ack_o(ack_o[1]),
      .m1_err_o (err_o[1]),
      .s_cyc_o  (s_cyc_o),   .s_stb_o  (s_stb_o),   .s_we_o  (s_we_o),
      .s_addr_o (s_addr_o),  .s_dat_o  (s_dat_o),   .s_sel_o (s_sel_o),
      .s_cti_o  (s_cti_o),   .s_dat_i  (s_dat_i),   .s_ack_i (s_ack_i),
      .gnt_o    (gnt_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic drop(input int n);
      mcyc[n] = 1'b0;
      mstb[n] = 1'b0;
   endtask

   task automatic req(input int n, input logic we, input logic [31:0] addr,
                      input logic [31:0] dat, input logic [2:0] cti);
      mcyc[n]  = 1'b1;
      mstb[n]  = 1'b1;
      mwe[n]   = we;
      maddr[n] = addr;
      mdat[n]  = dat;
      msel[n]  = 4'hF;
      mcti[n]  = cti;
   endtask

   task automatic clear_all();
      for (int n = 0; n < 2; n++) begin
         drop(n);
         mwe[n]   = 1'b0;
         maddr[n] = '0;
         mdat[n]  = '0;
         msel[n]  = '0;
         mcti[n]  = '0;
      end
      s_ack_i = 1'b0;
      s_dat_i = '0;
   endtask

   task automatic reset_dut();
      clear_all();
      wb_rst_n = 1'b0;
      tick();
      wb_rst_n = 1'b1;
   endtask

   // Tenure-level ownership model used for the randomized phase
   int         owner, last_own, wcnt, dly, beats [2];
   logic       pend, on, rq;
   int         oi;
   logic [1:0] eack;

   initial begin
      clear_all();
      wb_rst_n = 1'b0;
      mcyc = 2'b11;
      mstb = 2'b11;

      // Reset held with both masters requesting
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_gnt", gnt_o, 2'b00);
         chk("rst_s_cyc", s_cyc_o, 1'b0);
         chk("rst_acks", ack_o, 2'b00);
         chk("rst_errs", err_o, 2'b00);
      end
      clear_all();
      wb_rst_n = 1'b1;
      tick();

      // Single m0 write, slave acks two cycles after the request reaches it
      req(0, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000);
      #1;
      chk("wr_idle_s_cyc", s_cyc_o, 1'b0);
      chk("wr_idle_s_addr", s_addr_o, 32'h0);
      tick();
      chk("wr_s_addr", s_addr_o, 32'h100);
      chk("wr_s_dat", s_dat_o, 32'hDEADBEEF);
      chk("wr_s_we", s_we_o, 1'b1);
      chk("wr_s_sel", s_sel_o, 4'hF);
      chk("wr_gnt", gnt_o, 2'b01);
      chk("wr_no_ack_yet", ack_o[0], 1'b0);
      tick();
      tick();
      s_ack_i = 1'b1;
      #1;
      chk("wr_m0_ack", ack_o[0], 1'b1);
      chk("wr_m1_ack", ack_o[1], 1'b0);
      tick();
      s_ack_i = 1'b0;
      drop(0);
      #1;
      chk("wr_ack_pulse", ack_o[0], 1'b0);
      chk("wr_exit_s_cyc", s_cyc_o, 1'b0);
      chk("wr_exit_gnt", gnt_o, 2'b01);
      tick();
      chk("wr_idle_gnt", gnt_o, 2'b00);

      // Simultaneous requests after reset alternate m0, m1, m0, m1 with no idle gap
      reset_dut();
      req(0, 1'b0, 32'h200, 32'h0, 3'b000);
      req(1, 1'b0, 32'h300, 32'h0, 3'b000);
      #1;
      chk("rr_idle_gnt", gnt_o, 2'b00);
      tick();
      for (int k = 0; k < 4; k++) begin
         int e;
         e = k % 2;
         s_ack_i = 1'b1;
         s_dat_i = 32'h1000 + k;
         #1;
         chk("rr_gnt", gnt_o, (e == 0) ? 2'b01 : 2'b10);
         chk("rr_s_addr", s_addr_o, maddr[e]);
         chk("rr_own_ack", ack_o[e], 1'b1);
         chk("rr_oth_ack", ack_o[1-e], 1'b0);
         chk("rr_own_dat", dat_o[e], 32'h1000 + k);
         chk("rr_oth_dat", dat_o[1-e], 32'h0);
         tick();
         s_ack_i = 1'b0;
         drop(e);
         #1;
         chk("rr_exit_gnt", gnt_o, (e == 0) ? 2'b01 : 2'b10);
         chk("rr_exit_s_cyc", s_cyc_o, 1'b0);
         tick();
         mcyc[e] = 1'b1;
         mstb[e] = 1'b1;
      end
      #1;
      chk("rr_wrap_gnt", gnt_o, 2'b01);

      // m0 4-beat burst is not split by an m1 request
      reset_dut();
      req(0, 1'b1, 32'h400, 32'h11, 3'b010);
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i == 0) req(1, 1'b0, 32'h500, 32'h0, 3'b000);
         maddr[0] = 32'h400 + 4 * i;
         mcti[0]  = (i == 3) ? 3'b111 : 3'b010;
         s_ack_i  = 1'b1;
         #1;
         chk("bst_gnt", gnt_o, 2'b01);
         chk("bst_s_addr", s_addr_o, 32'h400 + 4 * i);
         chk("bst_s_cti", s_cti_o, mcti[0]);
         chk("bst_m0_ack", ack_o[0], 1'b1);
         chk("bst_m1_ack", ack_o[1], 1'b0);
         tick();
      end
      s_ack_i = 1'b0;
      drop(0);
      #1;
      chk("bst_hold_gnt", gnt_o, 2'b01);
      chk("bst_exit_s_cyc", s_cyc_o, 1'b0);
      tick();
      chk("bst_m1_gnt", gnt_o, 2'b10);
      chk("bst_m1_addr", s_addr_o, 32'h500);
      chk("bst_m1_cyc", s_cyc_o, 1'b1);
      s_ack_i = 1'b1;
      #1;
      chk("bst_m1_ack", ack_o[1], 1'b1);
      tick();
      s_ack_i = 1'b0;
      drop(1);

      // m1 stalled by a slave that never acks
      reset_dut();
      req(1, 1'b0, 32'h600, 32'h0, 3'b000);
      tick();
      req(0, 1'b0, 32'h680, 32'h0, 3'b000);
`ifdef SDRAM_WB_ARB_TIMEOUT_EN
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk("tmo_m1_err", err_o[1], (i == 8) ? 1'b1 : 1'b0);
         chk("tmo_m0_err", err_o[0], 1'b0);
         chk("tmo_s_cyc", s_cyc_o, 1'b1);
         tick();
      end
      s_ack_i = 1'b1;
      #1;
      chk("abt_s_cyc", s_cyc_o, 1'b0);
      chk("abt_s_stb", s_stb_o, 1'b0);
      chk("abt_late_ack", ack_o, 2'b00);
      chk("abt_err_pulse", err_o, 2'b00);
      tick();
      s_ack_i = 1'b0;
      drop(1);
      #1;
      chk("abt_wait_s_cyc", s_cyc_o, 1'b0);
      tick();
      chk("abt_m0_gnt", gnt_o, 2'b01);
      chk("abt_m0_cyc", s_cyc_o, 1'b1);
      chk("abt_m0_addr", s_addr_o, 32'h680);
`else
      for (int i = 1; i <= 12; i++) begin
         #1;
         chk("hang_errs", err_o, 2'b00);
         chk("hang_gnt", gnt_o, 2'b10);
         chk("hang_s_cyc", s_cyc_o, 1'b1);
         tick();
      end
      s_ack_i = 1'b1;
      #1;
      chk("hang_m1_ack", ack_o[1], 1'b1);
      tick();
      s_ack_i = 1'b0;
      drop(1);
      tick();
      chk("hang_m0_gnt", gnt_o, 2'b01);
`endif
      s_ack_i = 1'b1;
      #1;
      chk("tmo_m0_ack", ack_o[0], 1'b1);
      tick();
      s_ack_i = 1'b0;
      drop(0);
      tick();

      // m1 read data routed only to m1
      reset_dut();
      req(1, 1'b0, 32'h700, 32'h0, 3'b000);
      tick();
      s_ack_i = 1'b1;
      s_dat_i = 32'hA5A5A5A5;
      #1;
      chk("rd_m1_dat", dat_o[1], 32'hA5A5A5A5);
      chk("rd_m1_ack", ack_o[1], 1'b1);
      chk("rd_m0_dat", dat_o[0], 32'h0);
      chk("rd_m0_ack", ack_o[0], 1'b0);
      tick();
      clear_all();

      // Reset asserted mid-transfer suppresses the ack in that cycle
      req(0, 1'b0, 32'h800, 32'h0, 3'b000);
      tick();
      tick();
      s_ack_i  = 1'b1;
      wb_rst_n = 1'b0;
      #1;
      chk("mrst_ack", ack_o, 2'b00);
      chk("mrst_s_cyc", s_cyc_o, 1'b0);
      chk("mrst_gnt", gnt_o, 2'b00);
      tick();
      wb_rst_n = 1'b1;
      clear_all();

      // Randomized traffic from both masters against the ownership model
      reset_dut();
      owner = -1; last_own = 1; wcnt = 0; dly = 0; pend = 1'b0; eack = 2'b00;
      beats[0] = 0; beats[1] = 0;
      for (int c = 0; c < 3000; c++) begin
         tick();
         for (int n = 0; n < 2; n++) begin
            if (mcyc[n]) begin
               if (eack[n]) begin
                  beats[n]--;
                  if (beats[n] == 0) drop(n);
                  else begin
                     maddr[n] = maddr[n] + 32'd4;
                     mdat[n]  = $urandom;
                     msel[n]  = 4'($urandom);
                     mcti[n]  = (beats[n] == 1) ? 3'b111 : 3'b010;
                     mstb[n]  = ($urandom_range(0, 5) != 0);
                  end
               end else if (!mstb[n]) mstb[n] = 1'b1;
            end else if ($urandom_range(0, 3) == 0) begin
               beats[n] = $urandom_range(1, 4);
               req(n, 1'($urandom), $urandom & 32'hFFFF_FFF0, $urandom,
                   (beats[n] == 1) ? 3'b000 : 3'b010);
               msel[n] = 4'($urandom);
            end
         end
         s_ack_i = pend;
         s_dat_i = $urandom;
         #1;
         on = (owner >= 0);
         oi = on ? owner : 0;
         chk("rnd_gnt", gnt_o, !on ? 2'b00 : (oi == 0 ? 2'b01 : 2'b10));
         chk("rnd_s_cyc", s_cyc_o, on & mcyc[oi]);
         chk("rnd_s_stb", s_stb_o, on & mstb[oi]);
         chk("rnd_s_we", s_we_o, on & mwe[oi]);
         chk("rnd_s_addr", s_addr_o, on ? maddr[oi] : 32'h0);
         chk("rnd_s_dat", s_dat_o, on ? mdat[oi] : 32'h0);
         chk("rnd_s_sel", s_sel_o, on ? msel[oi] : 4'h0);
         chk("rnd_s_cti", s_cti_o, on ? mcti[oi] : 3'b000);
         for (int n = 0; n < 2; n++) begin
            eack[n] = on && (oi == n) && s_ack_i;
            chk("rnd_ack", ack_o[n], eack[n]);
            chk("rnd_dat", dat_o[n], (on && oi == n) ? s_dat_i : 32'h0);
            chk("rnd_err", err_o[n], 1'b0);
         end
         rq   = on && mcyc[oi] && mstb[oi];
         pend = 1'b0;
         if (s_ack_i) begin
            wcnt = 0;
            dly  = $urandom_range(0, 3);
         end else if (rq) begin
            if (wcnt >= dly) pend = 1'b1;
            else wcnt++;
         end
         if (!(on && mcyc[oi])) begin
            if (mcyc[0] && mcyc[1]) owner = 1 - last_own;
            else if (mcyc[0])       owner = 0;
            else if (mcyc[1])       owner = 1;
            else                    owner = -1;
            if (owner >= 0) last_own = owner;
         end
      end

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
